// File: rtl/mul_pipe_arb_if.sv
// Requester-side bus of mul_pipe_arb: packed per-requester operation requests in,
// owner-tagged multiplier results out.
interface mul_pipe_arb_if #(
  parameter int SIGN_W = 1,
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23,
  parameter int NREQ   = 4
);
  localparam int W   = SIGN_W + EXPO_W + MANT_W;
  localparam int IDW = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*2-1:0] req_rnd;
  logic [NREQ-1:0]   req_ready;

  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_r;
  logic              rsp_nv;

  modport master (
    output req_valid, req_a, req_b, req_rnd,
    input  req_ready, rsp_valid, rsp_id, rsp_r, rsp_nv
  );

  modport slave (
    input  req_valid, req_a, req_b, req_rnd,
    output req_ready, rsp_valid, rsp_id, rsp_r, rsp_nv
  );
endinterface

// File: rtl/mul_pipe_arb.sv
// Round-robin arbiter sharing one fixed-latency pipelined FP multiplier among NREQ requesters.
// Optional sticky per-requester invalid flags are built when MUL_PIPE_ARB_FFLAGS_EN is defined.
module mul_pipe_arb #(
  parameter int SIGN_W  = 1,
  parameter int EXPO_W  = 8,
  parameter int MANT_W  = 23,
  parameter int NREQ    = 4,
  parameter int LAT     = 3,
  parameter int MAX_OUT = 2,
  localparam int W      = SIGN_W + EXPO_W + MANT_W,
  localparam int IDW    = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  mul_pipe_arb_if.slave   bus,
  output logic            mul_issue,
  output logic [W-1:0]    mul_a,
  output logic [W-1:0]    mul_b,
  output logic [1:0]      mul_rnd,
  input  logic [W-1:0]    mul_r,
  input  logic            mul_nv,
  output logic            busy
`ifdef MUL_PIPE_ARB_FFLAGS_EN
  ,
  input  logic [NREQ-1:0] nv_clr,
  output logic [NREQ-1:0] nv_sticky
`endif
);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

  logic [IDW-1:0]            rr_ptr_reg;
  logic [NREQ-1:0][CW-1:0]   cnt_reg;
  logic [NREQ-1:0][CW-1:0]   cnt_next;
  logic [LAT-1:0]            tag_valid_reg;
  logic [IDW-1:0]            tag_id_reg [LAT];

  logic [NREQ-1:0]           eligible;
  logic [NREQ-1:0]           grant;
  logic [NREQ-1:0]           rsp_hit;
  logic [IDW-1:0]            gnt_id;
  logic                      gnt_any;

  assign bus.rsp_valid = tag_valid_reg[LAT-1];
  assign bus.rsp_id    = tag_id_reg[LAT-1];
  assign bus.rsp_r     = bus.rsp_valid ? mul_r : '0;
  assign bus.rsp_nv    = bus.rsp_valid & mul_nv;
  assign busy          = |tag_valid_reg;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign rsp_hit[gi] = bus.rsp_valid && (bus.rsp_id == IDW'(gi));
      // A slot retiring this cycle may be reused by a grant in the same cycle.
      assign eligible[gi] = rst_n && en && bus.req_valid[gi] &&
                            ((cnt_reg[gi] < MAX_CNT) || rsp_hit[gi]);
      assign cnt_next[gi] = (grant[gi] && !rsp_hit[gi]) ? cnt_reg[gi] + 1'b1 :
                            (!grant[gi] && rsp_hit[gi] && (cnt_reg[gi] != '0)) ?
                              cnt_reg[gi] - 1'b1 : cnt_reg[gi];
    end
  endgenerate

  always_comb begin
    grant   = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(rr_ptr_reg) + k) % NREQ;
      if (!gnt_any && eligible[idx]) begin
        gnt_any     = 1'b1;
        grant[idx]  = 1'b1;
        gnt_id      = IDW'(idx);
      end
    end
  end

  assign bus.req_ready = grant;
  assign mul_issue     = gnt_any;
  assign mul_a         = gnt_any ? bus.req_a[int'(gnt_id)*W +: W] : '0;
  assign mul_b         = gnt_any ? bus.req_b[int'(gnt_id)*W +: W] : '0;
  assign mul_rnd       = gnt_any ? bus.req_rnd[int'(gnt_id)*2 +: 2] : 2'b00;

  // Tag pipe mirrors the multiplier latency; it never stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_reg    <= '0;
      cnt_reg       <= '0;
      tag_valid_reg <= '0;
      for (int s = 0; s < LAT; s++) begin
        tag_id_reg[s] <= '0;
      end
    end else begin
      if (gnt_any) begin
        rr_ptr_reg <= (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
      end
      cnt_reg          <= cnt_next;
      tag_valid_reg[0] <= gnt_any;
      tag_id_reg[0]    <= gnt_id;
      for (int s = 1; s < LAT; s++) begin
        tag_valid_reg[s] <= tag_valid_reg[s-1];
        tag_id_reg[s]    <= tag_id_reg[s-1];
      end
    end
  end

`ifdef MUL_PIPE_ARB_FFLAGS_EN
  logic [NREQ-1:0] nv_sticky_reg;

  assign nv_sticky = nv_sticky_reg;

  // Set has priority over clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nv_sticky_reg <= '0;
    end else begin
      nv_sticky_reg <= (nv_sticky_reg & ~nv_clr) | (rsp_hit & {NREQ{bus.rsp_nv}});
    end
  end
`endif
endmodule

// File: tb/tb_mul_pipe_arb.sv
// Randomized self-checking bench for mul_pipe_arb, driving a stand-in pipelined multiplier
// and comparing every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_mul_pipe_arb;
  localparam int SIGN_W  = 1;
  localparam int EXPO_W  = 8;
  localparam int MANT_W  = 23;
  localparam int NREQ    = 4;
  localparam int LAT     = 3;
  localparam int MAX_OUT = 2;
  localparam int W       = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          mul_issue;
  logic [W-1:0]  mul_a;
  logic [W-1:0]  mul_b;
  logic [1:0]    mul_rnd;
  logic [W-1:0]  mul_r;
  logic          mul_nv;
  logic          busy;

  mul_pipe_arb_if #(.SIGN_W(SIGN_W), .EXPO_W(EXPO_W), .MANT_W(MANT_W), .NREQ(NREQ)) bus ();

`ifdef MUL_PIPE_ARB_FFLAGS_EN
  logic [NREQ-1:0] nv_clr;
  logic [NREQ-1:0] nv_sticky;
  logic [NREQ-1:0] clr_s;
  logic [NREQ-1:0] sticky_m;
`endif

  mul_pipe_arb #(
    .SIGN_W(SIGN_W), .EXPO_W(EXPO_W), .MANT_W(MANT_W),
    .NREQ(NREQ), .LAT(LAT), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .bus(bus),
    .mul_issue(mul_issue),
    .mul_a(mul_a),
    .mul_b(mul_b),
    .mul_rnd(mul_rnd),
    .mul_r(mul_r),
    .mul_nv(mul_nv),
    .busy(busy)
`ifdef MUL_PIPE_ARB_FFLAGS_EN
    ,
    .nv_clr(nv_clr),
    .nv_sticky(nv_sticky)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in multiplier: truncating product for normal operands, quiet NaN otherwise.
  function automatic logic [31:0] fake_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [22:0] m;
    int e;
    if (a[30:23] == 8'h00 || a[30:23] == 8'hFF || b[30:23] == 8'h00 || b[30:23] == 8'hFF)
      return 32'h7FC00000;
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    if (e <= 0 || e >= 255) return 32'h7FC00000;
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  function automatic logic is_snan(input logic [31:0] a);
    return (a[30:23] == 8'hFF) && (a[22:0] != 23'd0) && !a[22];
  endfunction

  logic [W-1:0] fm_r  [LAT];
  logic         fm_nv [LAT];

  always @(posedge clk) begin
    for (int s = LAT - 1; s > 0; s--) begin
      fm_r[s]  <= fm_r[s-1];
      fm_nv[s] <= fm_nv[s-1];
    end
    if (mul_issue) begin
      fm_r[0]  <= fake_mul(mul_a, mul_b);
      fm_nv[0] <= is_snan(mul_a) | is_snan(mul_b);
    end else begin
      fm_r[0]  <= $urandom;
      fm_nv[0] <= 1'($urandom_range(0, 1));
    end
  end

  assign mul_r  = fm_r[LAT-1];
  assign mul_nv = fm_nv[LAT-1];

  typedef struct {
    int          due;
    int          id;
    logic [31:0] r;
    logic        nv;
  } exp_t;

  exp_t            exp_q[$];
  int              cnt_m [NREQ];
  int              rr_m;
  int              cyc;
  int              last_g;
  int              rate;
  logic [NREQ-1:0] vld_s;
  logic [NREQ-1:0] refill_s;
  logic            rst_s;
  logic            en_s;
  logic [31:0]     a_s   [NREQ];
  logic [31:0]     b_s   [NREQ];
  logic [1:0]      rnd_s [NREQ];
  int              n_tests = 0;
  int              n_fail  = 0;
  int              lim_pat  [8] = '{1, 1, 0, 1, 1, 0, 1, 1};
  int              busy_pat [4] = '{1, 1, 1, 0};
  int              rsp_pat  [4] = '{0, 1, 1, 0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'h3F800000;
      1:       return 32'h40000000;
      2:       return 32'h7F800001;
      default: return $urandom;
    endcase
  endfunction

  task automatic new_op(input int i);
    vld_s[i] = 1'b1;
    a_s[i]   = pick_val();
    b_s[i]   = pick_val();
    rnd_s[i] = 2'($urandom_range(0, 3));
  endtask

  // One clock cycle: drive, compare against the model, then advance the model past the edge.
  task automatic cycle();
    int              g;
    logic            ev;
    exp_t            f;
    logic [NREQ-1:0] e_ready;
    @(negedge clk);
    rst_n = rst_s;
    en    = en_s;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]        = vld_s[i];
      bus.req_a[i*W +: W]     = a_s[i];
      bus.req_b[i*W +: W]     = b_s[i];
      bus.req_rnd[i*2 +: 2]   = rnd_s[i];
    end
`ifdef MUL_PIPE_ARB_FFLAGS_EN
    nv_clr = clr_s;
`endif
    #1;
    ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    if (ev) f = exp_q[0];
    g = -1;
    if (rst_s && en_s) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        int busy_slots;
        i = (rr_m + k) % NREQ;
        busy_slots = cnt_m[i] - ((ev && f.id == i) ? 1 : 0);
        if (g < 0 && vld_s[i] && busy_slots < MAX_OUT) g = i;
      end
    end
    e_ready = '0;
    if (g >= 0) e_ready[g] = 1'b1;
    check("req_ready", 64'(bus.req_ready), 64'(e_ready));
    check("mul_issue", 64'(mul_issue), 64'(g >= 0));
    check("mul_a",     64'(mul_a),   (g >= 0) ? 64'(a_s[g])   : 64'd0);
    check("mul_b",     64'(mul_b),   (g >= 0) ? 64'(b_s[g])   : 64'd0);
    check("mul_rnd",   64'(mul_rnd), (g >= 0) ? 64'(rnd_s[g]) : 64'd0);
    check("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
    if (ev) check("rsp_id", 64'(bus.rsp_id), 64'(f.id));
    check("rsp_r",     64'(bus.rsp_r),  ev ? 64'(f.r)  : 64'd0);
    check("rsp_nv",    64'(bus.rsp_nv), ev ? 64'(f.nv) : 64'd0);
    check("busy",      64'(busy), 64'(exp_q.size() > 0));
`ifdef MUL_PIPE_ARB_FFLAGS_EN
    check("nv_sticky", 64'(nv_sticky), 64'(sticky_m));
`endif
    last_g = g;
    if (!rst_s) begin
      exp_q.delete();
      for (int i = 0; i < NREQ; i++) cnt_m[i] = 0;
      rr_m = 0;
`ifdef MUL_PIPE_ARB_FFLAGS_EN
      sticky_m = '0;
`endif
    end else begin
`ifdef MUL_PIPE_ARB_FFLAGS_EN
      sticky_m = sticky_m & ~clr_s;
      if (ev && f.nv) sticky_m[f.id] = 1'b1;
`endif
      if (ev) begin
        cnt_m[f.id]--;
        void'(exp_q.pop_front());
      end
      if (g >= 0) begin
        cnt_m[g]++;
        rr_m = (g + 1) % NREQ;
        exp_q.push_back('{cyc + LAT, g, fake_mul(a_s[g], b_s[g]), is_snan(a_s[g]) | is_snan(b_s[g])});
      end
    end
    if (g >= 0) begin
      if (refill_s[g]) new_op(g);
      else vld_s[g] = 1'b0;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!vld_s[i] && int'($urandom_range(0, 99)) < rate) new_op(i);
    end
    cyc++;
  endtask

  initial begin
    vld_s = '0; refill_s = '0; rst_s = 1'b0; en_s = 1'b1; rate = 0;
    cyc = 0; rr_m = 0; last_g = -1;
    for (int i = 0; i < NREQ; i++) begin
      cnt_m[i] = 0; a_s[i] = '0; b_s[i] = '0; rnd_s[i] = '0;
    end
    rst_n = 1'b0; en = 1'b0;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_rnd = '0;
`ifdef MUL_PIPE_ARB_FFLAGS_EN
    clr_s = '0; sticky_m = '0; nv_clr = '0;
`endif
    repeat (3) cycle();
    rst_s = 1'b1;
    repeat (2) cycle();

    // Single op: 1.0 * 2.0 from req0
    vld_s[0] = 1'b1; a_s[0] = 32'h3F800000; b_s[0] = 32'h40000000; rnd_s[0] = 2'd0;
    cycle();
    check("single_grant", 64'(bus.req_ready), 64'h1);
    repeat (LAT) cycle();
    check("single_valid", 64'(bus.rsp_valid), 64'd1);
    check("single_id",    64'(bus.rsp_id),    64'd0);
    check("single_r",     64'(bus.rsp_r),     64'h40000000);
    check("single_nv",    64'(bus.rsp_nv),    64'd0);
    repeat (2) cycle();

    // Round-robin with every requester continuously valid
    rst_s = 1'b0; cycle(); rst_s = 1'b1;
    refill_s = '1;
    for (int i = 0; i < NREQ; i++) new_op(i);
    for (int k = 0; k < 8; k++) begin
      cycle();
      check("rr_order", 64'(last_g), 64'(k % NREQ));
    end
    refill_s = '0; vld_s = '0;
    repeat (LAT + 1) cycle();

    // Outstanding limit on req1
    refill_s = 4'b0010; new_op(1);
    for (int k = 0; k < 8; k++) begin
      cycle();
      check("limit_ready", 64'(bus.req_ready[1]), 64'(lim_pat[k]));
    end
    refill_s = '0; vld_s = '0;
    repeat (LAT + 1) cycle();

    // Signalling NaN from req2
`ifdef MUL_PIPE_ARB_FFLAGS_EN
    clr_s = '1; cycle(); clr_s = '0;
`endif
    vld_s[2] = 1'b1; a_s[2] = 32'h7F800001; b_s[2] = 32'h3F800000; rnd_s[2] = 2'd0;
    cycle();
    repeat (LAT) cycle();
    check("snan_id", 64'(bus.rsp_id), 64'd2);
    check("snan_nv", 64'(bus.rsp_nv), 64'd1);
`ifdef MUL_PIPE_ARB_FFLAGS_EN
    repeat (3) cycle();
    check("sticky_hold", 64'(nv_sticky), 64'h4);
    clr_s = 4'b0100; cycle(); clr_s = '0;
    cycle();
    check("sticky_clr", 64'(nv_sticky), 64'h0);
`endif
    repeat (2) cycle();

    // en=0 with two operations in flight
    new_op(0); new_op(1);
    cycle(); cycle();
    en_s = 1'b0;
    for (int i = 0; i < NREQ; i++) if (!vld_s[i]) new_op(i);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("en0_issue", 64'(mul_issue), 64'd0);
      check("en0_busy",  64'(busy), 64'(busy_pat[k]));
      check("en0_rsp",   64'(bus.rsp_valid), 64'(rsp_pat[k]));
    end
    vld_s = '0; en_s = 1'b1;
    repeat (2) cycle();

    // Reset with three operations in flight
    new_op(0); new_op(1); new_op(2);
    repeat (3) cycle();
    rst_s = 1'b0;
    for (int i = 0; i < NREQ; i++) if (!vld_s[i]) new_op(i);
    cycle();
    rst_s = 1'b1;
    cycle();
    check("rst_first_grant", 64'(bus.req_ready), 64'h1);
    check("rst_quiet", 64'(bus.rsp_valid), 64'd0);
    for (int k = 1; k < LAT; k++) begin
      cycle();
      check("rst_quiet", 64'(bus.rsp_valid), 64'd0);
    end
    vld_s = '0;
    repeat (LAT + 2) cycle();

    // Randomized traffic
    rate = 30;
    for (int n = 0; n < 3000; n++) begin
      en_s     = ($urandom_range(0, 7) != 0);
      rst_s    = ($urandom_range(0, 499) != 0);
      refill_s = NREQ'($urandom_range(0, 15));
`ifdef MUL_PIPE_ARB_FFLAGS_EN
      clr_s = ($urandom_range(0, 9) == 0) ? NREQ'($urandom_range(0, 15)) : '0;
`endif
      cycle();
    end
    rate = 0; vld_s = '0; refill_s = '0; rst_s = 1'b1; en_s = 1'b1;
`ifdef MUL_PIPE_ARB_FFLAGS_EN
    clr_s = '0;
`endif
    repeat (LAT + 2) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
